// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between requesters A and B.
// Grants are combinational; read data returns to its owner through a two-stage pipeline.
module dmem_arbiter #(
    parameter int AW = 21,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic          a_rvalid,
    output logic [DW-1:0] a_rdata,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic          b_rvalid,
    output logic [DW-1:0] b_rdata,
    output logic          m_write,
    output logic [AW-1:0] m_dst_addr,
    output logic [DW-1:0] m_dst,
    output logic [AW-1:0] m_src_addr,
    input  logic [DW-1:0] m_src
);

    logic          r_last_b;
    logic          r_vld_p1;
    logic          r_own_p1;
    logic          r_a_vld_p2;
    logic          r_b_vld_p2;
    logic [DW-1:0] r_a_rdata_p2;
    logic [DW-1:0] r_b_rdata_p2;

    logic          w_a_gnt;
    logic          w_b_gnt;
    logic          w_a_rd;
    logic          w_b_rd;
    logic          w_a_wr;
    logic          w_b_wr;

    // On contention the requester that did not win last time is served.
    always_comb begin
        w_a_gnt = a_req & (~b_req | r_last_b);
        w_b_gnt = b_req & ~w_a_gnt;
        w_a_rd  = w_a_gnt & ~a_we;
        w_b_rd  = w_b_gnt & ~b_we;
        w_a_wr  = w_a_gnt & a_we & rst_n;
        w_b_wr  = w_b_gnt & b_we & rst_n;
    end

    always_comb begin
        m_write    = w_a_wr | w_b_wr;
        m_dst_addr = '0;
        m_dst      = '0;
        m_src_addr = '0;
        if (w_a_wr) begin
            m_dst_addr = a_addr;
            m_dst      = a_wdata;
        end else if (w_b_wr) begin
            m_dst_addr = b_addr;
            m_dst      = b_wdata;
        end
        if (w_a_rd) begin
            m_src_addr = a_addr;
        end else if (w_b_rd) begin
            m_src_addr = b_addr;
        end
    end

    assign a_gnt    = w_a_gnt;
    assign b_gnt    = w_b_gnt;
    assign a_rvalid = r_a_vld_p2;
    assign b_rvalid = r_b_vld_p2;
    assign a_rdata  = r_a_rdata_p2;
    assign b_rdata  = r_b_rdata_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_b     <= 1'b1;
            r_vld_p1     <= 1'b0;
            r_own_p1     <= 1'b0;
            r_a_vld_p2   <= 1'b0;
            r_b_vld_p2   <= 1'b0;
            r_a_rdata_p2 <= '0;
            r_b_rdata_p2 <= '0;
        end else begin
            if (w_a_gnt) begin
                r_last_b <= 1'b0;
            end else if (w_b_gnt) begin
                r_last_b <= 1'b1;
            end
            // Stage 1: remember who owns the read in flight at the memory.
            r_vld_p1   <= w_a_rd | w_b_rd;
            r_own_p1   <= w_b_rd;
            // Stage 2: memory data is valid now; steer it to the owner.
            r_a_vld_p2 <= r_vld_p1 & ~r_own_p1;
            r_b_vld_p2 <= r_vld_p1 & r_own_p1;
            if (r_vld_p1 && !r_own_p1) begin
                r_a_rdata_p2 <= m_src;
            end
            if (r_vld_p1 && r_own_p1) begin
                r_b_rdata_p2 <= m_src;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: stimulus pushes expected read responses into
// per-requester queues, a negedge monitor pops and compares them on rvalid.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_we, b_req, b_we;
    logic [20:0] a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [15:0] a_rdata, b_rdata;
    logic        m_write;
    logic [20:0] m_dst_addr, m_src_addr;
    logic [15:0] m_dst, m_src;

    typedef struct {
        logic [15:0] d;
        int          c;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    logic [15:0] mem [logic [20:0]];

    dmem_arbiter #(.AW(21), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .m_write(m_write), .m_dst_addr(m_dst_addr), .m_dst(m_dst),
        .m_src_addr(m_src_addr), .m_src(m_src)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memory model: read sees contents from before this edge's write.
    always @(posedge clk) begin
        logic [15:0] rd;
        rd = mem.exists(m_src_addr) ? mem[m_src_addr] : 16'h0000;
        if (m_write) mem[m_dst_addr] = m_dst;
        m_src <= rd;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (a_rvalid) begin
                if (qa.size() == 0) begin
                    check("a_rvalid_unexpected", 32'd1, 32'd0);
                end else begin
                    e = qa.pop_front();
                    check("a_rdata", {16'h0, a_rdata}, {16'h0, e.d});
                    check("a_rvalid_cycle", cyc, e.c);
                end
            end
            if (b_rvalid) begin
                if (qb.size() == 0) begin
                    check("b_rvalid_unexpected", 32'd1, 32'd0);
                end else begin
                    e = qb.pop_front();
                    check("b_rdata", {16'h0, b_rdata}, {16'h0, e.d});
                    check("b_rvalid_cycle", cyc, e.c);
                end
            end
        end
    end

    // One cycle: drive requests, check grants and memory port at negedge, queue read expectations.
    task automatic step(input logic ar, input logic aw, input logic [20:0] aa, input logic [15:0] ad,
                        input logic br, input logic bw, input logic [20:0] ba, input logic [15:0] bd,
                        input logic eag, input logic ebg, input logic [15:0] erd);
        logic        ewr;
        logic [20:0] edst, esrc;
        logic [15:0] edat;
        exp_t        e;
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        @(negedge clk);
        check("a_gnt", {31'h0, a_gnt}, {31'h0, eag});
        check("b_gnt", {31'h0, b_gnt}, {31'h0, ebg});
        ewr  = (eag & aw) | (ebg & bw);
        edst = (eag & aw) ? aa : (ebg & bw) ? ba : 21'h0;
        edat = (eag & aw) ? ad : (ebg & bw) ? bd : 16'h0;
        esrc = (eag & ~aw) ? aa : (ebg & ~bw) ? ba : 21'h0;
        check("m_write", {31'h0, m_write}, {31'h0, ewr});
        check("m_dst_addr", {11'h0, m_dst_addr}, {11'h0, edst});
        check("m_dst", {16'h0, m_dst}, {16'h0, edat});
        check("m_src_addr", {11'h0, m_src_addr}, {11'h0, esrc});
        e.d = erd;
        e.c = cyc + 2;
        if (eag && !aw) qa.push_back(e);
        if (ebg && !bw) qb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 21'h0, 16'h0, 1'b0, 1'b0, 21'h0, 16'h0, 1'b0, 1'b0, 16'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ia, ib;
        for (int i = 0; i < 8; i++) begin
            mem[21'h100 + 21'(i)] = 16'hA000 + 16'(i);
            mem[21'h200 + 21'(i)] = 16'hB000 + 16'(i);
        end
        rst_n = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 21'h100; a_wdata = 16'h0;
        b_req = 1'b1; b_we = 1'b0; b_addr = 21'h200; b_wdata = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_a_gnt", {31'h0, a_gnt}, 32'd1);
        check("rst_b_gnt", {31'h0, b_gnt}, 32'd0);
        check("rst_m_write", {31'h0, m_write}, 32'd0);
        check("rst_a_rvalid", {31'h0, a_rvalid}, 32'd0);
        check("rst_b_rvalid", {31'h0, b_rvalid}, 32'd0);
        check("rst_a_rdata", {16'h0, a_rdata}, 32'h0);
        check("rst_b_rdata", {16'h0, b_rdata}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Both saturating reads: grants must alternate A,B,A,B with no idle cycle.
        ia = 0; ib = 0;
        for (int k = 0; k < 12; k++) begin
            if (k % 2 == 0) begin
                step(1'b1, 1'b0, 21'h100 + 21'(ia), 16'h0, 1'b1, 1'b0, 21'h200 + 21'(ib), 16'h0,
                     1'b1, 1'b0, 16'hA000 + 16'(ia));
                ia++;
            end else begin
                step(1'b1, 1'b0, 21'h100 + 21'(ia), 16'h0, 1'b1, 1'b0, 21'h200 + 21'(ib), 16'h0,
                     1'b0, 1'b1, 16'hB000 + 16'(ib));
                ib++;
            end
        end
        idle(3);
        check("idle_a_rdata_hold", {16'h0, a_rdata}, 32'hA005);
        check("idle_b_rdata_hold", {16'h0, b_rdata}, 32'hB005);

        // A writes then reads back the same word.
        step(1'b1, 1'b1, 21'h00010, 16'hBEEF, 1'b0, 1'b0, 21'h0, 16'h0, 1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b0, 21'h00010, 16'h0, 1'b0, 1'b0, 21'h0, 16'h0, 1'b1, 1'b0, 16'hBEEF);
        idle(2);
        check("wr_rd_a_rdata", {16'h0, a_rdata}, 32'hBEEF);

        // B writes the top address, A reads it on the very next grant.
        step(1'b0, 1'b0, 21'h0, 16'h0, 1'b1, 1'b1, 21'h1FFFFF, 16'h1234, 1'b0, 1'b1, 16'h0);
        step(1'b1, 1'b0, 21'h1FFFFF, 16'h0, 1'b0, 1'b0, 21'h0, 16'h0, 1'b1, 1'b0, 16'h1234);
        idle(2);

        // B alone for four cycles, then contention goes to A.
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 21'h0, 16'h0, 1'b1, 1'b0, 21'h200 + 21'(i), 16'h0,
                 1'b0, 1'b1, 16'hB000 + 16'(i));
        step(1'b1, 1'b0, 21'h103, 16'h0, 1'b1, 1'b0, 21'h204, 16'h0, 1'b1, 1'b0, 16'hA003);
        step(1'b0, 1'b0, 21'h0, 16'h0, 1'b1, 1'b0, 21'h204, 16'h0, 1'b0, 1'b1, 16'hB004);
        idle(3);
        check("solo_b_rdata", {16'h0, b_rdata}, 32'hB004);

        // Reset pulse one cycle after a read grant discards the in-flight read.
        step(1'b1, 1'b0, 21'h101, 16'h0, 1'b0, 1'b0, 21'h0, 16'h0, 1'b1, 1'b0, 16'hA001);
        a_req = 1'b0;
        rst_n = 1'b0;
        qa.delete();
        qb.delete();
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmid_a_rdata", {16'h0, a_rdata}, 32'h0);
        check("rstmid_b_rdata", {16'h0, b_rdata}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        check("rstmid_a_rvalid", {31'h0, a_rvalid}, 32'd0);
        check("rstmid_b_rvalid", {31'h0, b_rvalid}, 32'd0);
        @(posedge clk);
        #1;
        idle(3);
        check("rstmid_a_rdata_idle", {16'h0, a_rdata}, 32'h0);

        check("qa_drained", qa.size(), 32'd0);
        check("qb_drained", qb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port round-robin arbiter that shares the single-ported 16-bit data memory (write port plus synchronous-read port, 21-bit word address, one-cycle read latency) between two requesters, A and B. It sits between the memory and the two masters, typically the load/store unit (A) and a DMA/debug loader (B). It issues at most one memory operation per cycle and returns read data to the requester that issued the read.

## Interface
- AW, 21, word-address width (matches memory address ports)
- DW, 16, data width
- clk  in  1  single clock; all state updates on posedge
- rst_n  in  1  asynchronous, active-low reset
- a_req  in  1  requester A has an operation pending; held until a_gnt
- a_we  in  1  1 = write, 0 = read; stable while a_req high
- a_addr  in  AW  word address; stable while a_req high
- a_wdata  in  DW  write data; stable while a_req high
- a_gnt  out  1  combinational; operation accepted this cycle
- a_rvalid  out  1  registered; a_rdata holds read result this cycle
- a_rdata  out  DW  registered read data
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as A for requester B
- m_write  out  1  memory write enable
- m_dst_addr  out  AW  memory write address
- m_dst  out  DW  memory write data
- m_src_addr  out  AW  memory read address
- m_src  in  DW  memory read data, valid one cycle after address presented

## Operation
- Grant: at most one of a_gnt/b_gnt per cycle. Single requester: granted immediately. Both requesting: winner is the one NOT recorded in last register `last_b` (1 = B won last contested or uncontested grant). Any grant updates `last_b`.
- Granted write: m_write=1, m_dst_addr=addr, m_dst=wdata same cycle; memory commits at that posedge. No read-data response for writes.
- Granted read: m_src_addr=addr same cycle; m_write=0. Pipeline stage 1 registers {valid, owner}; stage 2 captures m_src into owner's rdata register and pulses owner's rvalid.
- Idle or write cycle: m_src_addr driven to 0; m_write=0 when no write granted; m_dst_addr/m_dst driven to 0 when no write granted.
- a_rdata/b_rdata hold last captured value until that requester's next read completes.
- Reads and writes pipeline back-to-back: a new grant is allowed every cycle regardless of outstanding reads.
- Write-then-read same address on consecutive grants (either requester): read returns the newly written data (write commits before the read address is sampled).
- Requester dropping req without gnt: illegal; behaviour unspecified, no assertion required.

## Timing
- Reset (rst_n low, asynchronous): last_b=1 (A wins first tie), both pipeline stages invalid, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0. Combinational outputs: gnt follows req per rules even during reset deassertion edge; m_write=0 while rst_n low.
- Read latency: grant in cycle N -> rvalid high in cycle N+2 exactly, for one cycle.
- Write latency: grant in cycle N -> data visible to a read granted in N+1 or later.
- Throughput: one operation per cycle; with both requesters saturating, grants alternate A,B,A,B.
- Reset mid-operation: in-flight reads discarded; no rvalid after reset release until a new read is granted.

## Test plan
- Reset, then A writes 16'hBEEF to 21'h00010 -> a_gnt=1 that cycle, m_write=1, m_dst_addr=21'h00010; A then reads 21'h00010 -> a_rvalid exactly 2 cycles after grant, a_rdata=16'hBEEF.
- Both req held continuously from reset, 6 reads each -> grant order A,B,A,B,...; each rvalid routed to correct owner with its own address's data, no cycle without a grant.
- B writes 16'h1234 to 21'h1FFFFF (max address) in cycle N, A reads 21'h1FFFFF granted N+1 -> a_rdata=16'h1234 at N+3.
- Only B requesting for 4 cycles, then A and B together -> B granted each solo cycle; on contention A wins (last_b=1).
- Read granted in cycle N, rst_n pulsed low in N+1 -> no a_rvalid/b_rvalid in N+2, rdata registers read 0.
- Idle cycles with no req -> a_gnt=b_gnt=0, m_write=0, m_src_addr=0, rdata registers unchanged.
